// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multicycle controller and ALU:
// FSM states, opcode/funct constants and ALUControl encodings.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_MUL = 6'b011000;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU decoder: ALUOp (add/sub/funct) plus funct to ALUControl,
// with a flag telling whether funct is one of the supported R-type operations.
module mips_alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_valid
);

  logic [2:0] funct_control;

  always_comb begin
    funct_control = ALU_ADD;
    funct_valid   = 1'b1;
    case (funct)
      FN_AND:  funct_control = ALU_AND;
      FN_OR:   funct_control = ALU_OR;
      FN_ADD:  funct_control = ALU_ADD;
      FN_SUB:  funct_control = ALU_SUB;
      FN_MUL:  funct_control = ALU_MUL;
      FN_SLT:  funct_control = ALU_SLT;
      default: funct_valid   = 1'b0;
    endcase
  end

  // The unused ALUOp code 11 falls back to add.
  always_comb begin
    case (alu_op)
      ALUOP_SUB:   alu_control = ALU_SUB;
      ALUOP_FUNCT: alu_control = funct_control;
      default:     alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM: state register, next-state decode, Moore output
// decode and the Mealy PC enable that resolves beq with the ALU zero flag.
module mips_mc_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero_flag,
  output logic [2:0] ALUControl,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       illegal_op
);

  state_t     state_reg;
  state_t     state_next;
  logic [1:0] alu_op;
  logic       alu_use;
  logic [2:0] dec_control;
  logic       funct_valid;
  logic       pc_write;
  logic       branch;
  logic       instr_illegal;

  mips_alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct       (funct),
    .alu_control (dec_control),
    .funct_valid (funct_valid)
  );

  assign instr_illegal = !op_supported(op) || ((op == OP_RTYPE) && !funct_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_FETCH;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        if (instr_illegal)                     state_next = S_FETCH;
        else if (op == OP_LW || op == OP_SW)   state_next = S_MEMADR;
        else if (op == OP_RTYPE)               state_next = S_RTYPEEX;
        else if (op == OP_BEQ)                 state_next = S_BEQEX;
        else if (op == OP_ADDI)                state_next = S_ADDIEX;
        else                                   state_next = S_JEX;
      end
      S_MEMADR:  state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_next = S_MEMWB;
      S_RTYPEEX: state_next = S_RTYPEWB;
      S_ADDIEX:  state_next = S_ADDIWB;
      default:   state_next = S_FETCH;
    endcase
  end

  // Reset overrides every output combinationally so in-flight writes drop at once.
  always_comb begin
    alu_op     = ALUOP_ADD;
    alu_use    = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    PCSrc      = 2'b00;
    pc_write   = 1'b0;
    branch     = 1'b0;
    illegal_op = 1'b0;
    case (state_reg)
      S_FETCH: begin
        IRWrite  = 1'b1;
        alu_use  = 1'b1;
        ALUSrcB  = 2'b01;
        pc_write = 1'b1;
      end
      S_DECODE: begin
        alu_use    = 1'b1;
        ALUSrcB    = 2'b11;
        illegal_op = instr_illegal;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_use = 1'b1;
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_RTYPEEX: begin
        alu_use = 1'b1;
        alu_op  = ALUOP_FUNCT;
        ALUSrcA = 1'b1;
      end
      S_RTYPEWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BEQEX: begin
        alu_use = 1'b1;
        alu_op  = ALUOP_SUB;
        ALUSrcA = 1'b1;
        PCSrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_JEX: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
    ALUControl = alu_use ? dec_control : 3'b000;
    PCEn       = pc_write | (branch & zero_flag);
    if (rst) begin
      ALUControl = 3'b000;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      IorD       = 1'b0;
      IRWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      PCSrc      = 2'b00;
      PCEn       = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller: walks each instruction class cycle by
// cycle and compares the packed control word against hand-written per-state values.
module tb_mips_mc_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero_flag;
  logic [2:0] ALUControl;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       IorD;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic       illegal_op;

  int checks = 0;
  int errors = 0;

  mips_mc_controller dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct      (funct),
    .zero_flag  (zero_flag),
    .ALUControl (ALUControl),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .IorD       (IorD),
    .IRWrite    (IRWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .PCSrc      (PCSrc),
    .PCEn       (PCEn),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  // Control word: ALUControl[15:13] ALUSrcA[12] ALUSrcB[11:10] IorD[9] IRWrite[8]
  // MemWrite[7] RegWrite[6] RegDst[5] MemtoReg[4] PCSrc[3:2] PCEn[1] illegal_op[0]
  logic [15:0] ctrl_word;
  assign ctrl_word = {ALUControl, ALUSrcA, ALUSrcB, IorD, IRWrite, MemWrite,
                      RegWrite, RegDst, MemtoReg, PCSrc, PCEn, illegal_op};

  localparam logic [15:0] W_ZERO    = 16'b000_0_00_0_0_0_0_0_0_00_0_0;
  localparam logic [15:0] W_FETCH   = 16'b010_0_01_0_1_0_0_0_0_00_1_0;
  localparam logic [15:0] W_DECODE  = 16'b010_0_11_0_0_0_0_0_0_00_0_0;
  localparam logic [15:0] W_DEC_ILL = 16'b010_0_11_0_0_0_0_0_0_00_0_1;
  localparam logic [15:0] W_MEMADR  = 16'b010_1_10_0_0_0_0_0_0_00_0_0;
  localparam logic [15:0] W_MEMRD   = 16'b000_0_00_1_0_0_0_0_0_00_0_0;
  localparam logic [15:0] W_MEMWB   = 16'b000_0_00_0_0_0_1_0_1_00_0_0;
  localparam logic [15:0] W_MEMWR   = 16'b000_0_00_1_0_1_0_0_0_00_0_0;
  localparam logic [15:0] W_RTWB    = 16'b000_0_00_0_0_0_1_1_0_00_0_0;
  localparam logic [15:0] W_BEQ_T   = 16'b100_1_00_0_0_0_0_0_0_01_1_0;
  localparam logic [15:0] W_BEQ_NT  = 16'b100_1_00_0_0_0_0_0_0_01_0_0;
  localparam logic [15:0] W_ADDIEX  = 16'b010_1_10_0_0_0_0_0_0_00_0_0;
  localparam logic [15:0] W_ADDIWB  = 16'b000_0_00_0_0_0_1_0_0_00_0_0;
  localparam logic [15:0] W_JEX     = 16'b000_0_00_0_0_0_0_0_0_10_1_0;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b expected=%b", tag, got, exp);
    end
  endtask

  // Check the current cycle's outputs, then move just past the next rising edge.
  task automatic cyc(input string tag, input logic [15:0] exp);
    #1;
    check_val(tag, ctrl_word, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic run_rtype(input logic [5:0] fn, input logic [2:0] ctl);
    op = 6'b000000;
    funct = fn;
    cyc("rt_fetch", W_FETCH);
    cyc("rt_decode", W_DECODE);
    cyc("rt_ex", {ctl, 13'b1_00_0_0_0_0_0_0_00_0_0});
    cyc("rt_wb", W_RTWB);
    $display("rtype funct=%b alu=%b done", fn, ctl);
  endtask

  initial begin
    rst = 1'b1;
    op = 6'b100011;
    funct = 6'b000000;
    zero_flag = 1'b0;
    @(posedge clk);
    #1;
    check_val("reset_hold", ctrl_word, W_ZERO);
    rst = 1'b0;

    // lw: 5 cycles; zero_flag toggled in MEMADR must be ignored
    cyc("lw_fetch", W_FETCH);
    cyc("lw_decode", W_DECODE);
    zero_flag = 1'b1;
    cyc("lw_memadr", W_MEMADR);
    zero_flag = 1'b0;
    cyc("lw_memrd", W_MEMRD);
    cyc("lw_memwb", W_MEMWB);
    $display("lw done");

    run_rtype(6'b101010, 3'b110);
    run_rtype(6'b100100, 3'b000);
    run_rtype(6'b100101, 3'b001);
    run_rtype(6'b100000, 3'b010);
    run_rtype(6'b100010, 3'b100);
    run_rtype(6'b011000, 3'b101);

    // beq taken then not taken
    op = 6'b000100;
    cyc("beq_fetch", W_FETCH);
    cyc("beq_decode", W_DECODE);
    zero_flag = 1'b1;
    cyc("beq_taken", W_BEQ_T);
    zero_flag = 1'b0;
    cyc("beq2_fetch", W_FETCH);
    cyc("beq2_decode", W_DECODE);
    cyc("beq_not_taken", W_BEQ_NT);
    $display("beq done");

    // addi
    op = 6'b001000;
    cyc("addi_fetch", W_FETCH);
    cyc("addi_decode", W_DECODE);
    cyc("addi_ex", W_ADDIEX);
    cyc("addi_wb", W_ADDIWB);
    $display("addi done");

    // illegal opcode, then illegal funct: 2 cycles each
    op = 6'b111111;
    cyc("ill_op_fetch", W_FETCH);
    cyc("ill_op_decode", W_DEC_ILL);
    op = 6'b000000;
    funct = 6'b000001;
    cyc("ill_fn_fetch", W_FETCH);
    cyc("ill_fn_decode", W_DEC_ILL);
    $display("illegal op and funct done");

    // j, followed by FETCH
    op = 6'b000010;
    cyc("j_fetch", W_FETCH);
    cyc("j_decode", W_DECODE);
    cyc("j_ex", W_JEX);
    op = 6'b101011;
    cyc("after_j_fetch", W_FETCH);
    $display("j done");

    // sw with reset asserted in MEMWR
    cyc("sw_decode", W_DECODE);
    cyc("sw_memadr", W_MEMADR);
    #1;
    check_val("sw_memwr", ctrl_word, W_MEMWR);
    rst = 1'b1;
    #1;
    check_val("sw_rst_same_cycle", ctrl_word, W_ZERO);
    @(posedge clk);
    #1;
    check_val("sw_rst_held", ctrl_word, W_ZERO);
    rst = 1'b0;
    cyc("post_rst_fetch", W_FETCH);
    cyc("post_rst_decode", W_DECODE);
    cyc("post_rst_memadr", W_MEMADR);
    cyc("post_rst_memwr", W_MEMWR);
    cyc("post_rst_back_fetch", W_FETCH);
    $display("sw with reset done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
